// File: rtl/cont8b_arbiter.sv
// cont8b_arbiter: time-slot arbiter that shares one external CW-bit up-counter
// between NREQ requesters. It is the sole driver of the counter's clear and
// enable. Each grant clears the counter, enables it for exactly len_l counts,
// and then pulses done to the owner.
// Build option: define CONT8B_ARB_FIXED_PRIO_EN for fixed lowest-index
// priority. When it is undefined, a round-robin pointer is used.
module cont8b_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               cnt_clr,
  output logic               cnt_ena,
  input  logic [CW-1:0]      cnt_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   len_l;
  logic [NREQ-1:0] rot;
  logic            found;
  logic [PW-1:0]   off;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [CW-1:0]   win_len;
  logic            owner_req;
  logic            last_cnt;

  assign busy      = (state != IDLE);
  assign owner_req = |(req & grant);
  assign last_cnt  = (cnt_q == len_l - CW'(1));

  // First set request in the (possibly rotated) request vector
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = PW'(i);
      end
    end
  end

  // One-hot winner and its requested length
  always_comb begin
    win_oh  = '0;
    win_len = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (found && (win_idx == PW'(i))) begin
        win_oh[i] = 1'b1;
        win_len   = len[i*CW +: CW];
      end
    end
  end

`ifdef CONT8B_ARB_FIXED_PRIO_EN
  assign rot     = req;
  assign win_idx = off;
`else
  localparam logic [PW:0]   NSUM = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] own;
  logic [PW:0]   idx_sum;
  logic          advance;

  // Rotate requests so that index 0 of rot corresponds to the pointer
  assign rot = NREQ'({req, req} >> ptr);

  // Map the rotated offset back to an absolute requester index (mod NREQ)
  always_comb begin
    idx_sum = {1'b0, ptr} + {1'b0, off};
    if (idx_sum >= NSUM) idx_sum = idx_sum - NSUM;
  end

  assign win_idx = idx_sum[PW-1:0];
  assign advance = (state == DONE) ||
                   (((state == CLEAR) || (state == RUN)) && !owner_req);

  // Remember the owner at grant time and advance the pointer past it when the service ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      own <= '0;
    end else begin
      if ((state == IDLE) && found) own <= win_idx;
      if (advance) ptr <= (own == LAST) ? '0 : own + PW'(1);
    end
  end
`endif

  // Main FSM with registered Moore outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      cnt_clr <= 1'b1;
      cnt_ena <= 1'b0;
      len_l   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          cnt_clr <= 1'b0;
          cnt_ena <= 1'b0;
          if (found) begin
            state   <= CLEAR;
            grant   <= win_oh;
            len_l   <= win_len;
            cnt_clr <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_clr <= 1'b0;
          if (!owner_req) begin
            state   <= IDLE;
            grant   <= '0;
            cnt_ena <= 1'b0;
          end else if (len_l == '0) begin
            state <= DONE;
            done  <= grant;
          end else begin
            state   <= RUN;
            cnt_ena <= 1'b1;
          end
        end
        RUN: begin
          // The counter makes its last increment on the edge that leaves RUN
          if (!owner_req) begin
            state   <= IDLE;
            grant   <= '0;
            cnt_ena <= 1'b0;
          end else if (last_cnt) begin
            state   <= DONE;
            cnt_ena <= 1'b0;
            done    <= grant;
          end
        end
        DONE: begin
          state   <= IDLE;
          grant   <= '0;
          cnt_ena <= 1'b0;
          cnt_clr <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          grant   <= '0;
          cnt_ena <= 1'b0;
          cnt_clr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cont8b_arbiter.sv
// Testbench for cont8b_arbiter. It includes a stand-in for the shared counter
// and a transaction-level reference: a winner-picking rule plus the expected
// grant window of len+2 cycles with len enabled cycles.
module tb_cont8b_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               cnt_clr;
  logic               cnt_ena;
  logic [CW-1:0]      cnt_q;

  int checks   = 0;
  int errors   = 0;
  int ptr_m    = 0;
  int last_lat = 0;

  always #5 clk = ~clk;

  cont8b_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .grant(grant), .done(done),
    .busy(busy), .cnt_clr(cnt_clr), .cnt_ena(cnt_ena), .cnt_q(cnt_q)
  );

  // Shared counter: asynchronous clear, count while enabled
  always @(posedge clk or posedge cnt_clr) begin
    if (cnt_clr) cnt_q <= '0;
    else if (cnt_ena) cnt_q <= cnt_q + CW'(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule: scan upward from the pointer and wrap around
  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    int s;
    s = p;
`ifdef CONT8B_ARB_FIXED_PRIO_EN
    s = 0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (m[(s + k) % NREQ]) return (s + k) % NREQ;
    return 0;
  endfunction

  function automatic int len_of(input int w);
    return int'(len[w*CW +: CW]);
  endfunction

  // Wait for a grant to w, then follow the service through to done
  task automatic serve(input int w, input int L, input bit jitter, input string tag);
    int t, ena_n, win;
    t = 0;
    do begin @(negedge clk); t++; end while (grant == '0 && t < 64);
    last_lat = t;
    chk({tag, "_grant"}, 32'(grant), 32'(1) << w);
    chk({tag, "_clear"}, 32'({cnt_clr, cnt_ena}), 32'h2);
    if (jitter) begin
      len[w*CW +: CW] = CW'($urandom);
      req = NREQ'($urandom) | (NREQ'(1) << w);
    end
    ena_n = 0;
    win   = 1;
    do begin
      @(negedge clk);
      win++;
      if (cnt_ena) ena_n++;
    end while (done == '0 && win < L + 6);
    chk({tag, "_done"}, 32'(done), 32'(1) << w);
    chk({tag, "_q_at_done"}, 32'(cnt_q), 32'(L));
    chk({tag, "_ena_cycles"}, 32'(ena_n), 32'(L));
    chk({tag, "_window"}, 32'(win), 32'(L + 2));
    chk({tag, "_grant_in_done"}, 32'(grant), 32'(1) << w);
    ptr_m = (w + 1) % NREQ;
  endtask

  // Invariants sampled every cycle
  always @(negedge clk) begin
    chk("inv_onehot", 32'($countones(grant) <= 1), 32'(1));
    chk("inv_clr_ena", 32'(cnt_clr & cnt_ena), 32'(0));
    chk("inv_busy", 32'(busy), 32'(grant != '0));
    chk("inv_done_owner", 32'(done), (done == '0) ? 32'(0) : 32'(grant));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] m;
    int w, t, n;
    int exp_seq[6];

    // Reset with every requester asking
    rst = 1'b1;
    req = '1;
    for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = CW'($urandom_range(1, 9));
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_clr", 32'(cnt_clr), 32'(1));
    chk("rst_ena", 32'(cnt_ena), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    ptr_m = 0;
    w = pick(req, ptr_m);
    serve(w, len_of(w), 1'b0, "rst_release");
    chk("rst_release_latency", 32'(last_lat), 32'(1));
    req = '0;

    // Fairness: 1011 held, all lengths 3, starting from a fresh pointer
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req = 4'b1011;
    for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = CW'(3);
    rst = 1'b0;
    ptr_m = 0;
`ifdef CONT8B_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 3, 0, 1, 3};
`endif
    for (int k = 0; k < 6; k++) serve(exp_seq[k], 3, 1'b0, "fair");
    req = '0;

    // Single request, length 5
    req = 4'b0100;
    len[2*CW +: CW] = CW'(5);
    serve(2, 5, 1'b0, "single");
    req = '0;
    @(negedge clk);
    chk("single_grant_after", 32'(grant), 32'(0));
    chk("single_done_once", 32'(done), 32'(0));

    // Boundary: zero length
    req = 4'b0001;
    len[0 +: CW] = '0;
    serve(0, 0, 1'b0, "len0");
    req = '0;

    // Boundary: full-scale length, the counter must not wrap
    req = 4'b0010;
    len[CW +: CW] = '1;
    serve(1, 255, 1'b0, "len255");
    req = '0;
    @(negedge clk);
    chk("len255_hold", 32'(cnt_q), 32'(255));

    // Abandon in RUN, with requester 2 waiting
    req = 4'b0010;
    len[CW +: CW]   = CW'(20);
    len[2*CW +: CW] = CW'(4);
    t = 0;
    do begin @(negedge clk); t++; end while (grant == '0 && t < 64);
    chk("abn_grant", 32'(grant), 32'h2);
    req = 4'b0110;
    n = 0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (cnt_ena) n++;
    end while (n < 7 && t < 40);
    chk("abn_q_run7", 32'(cnt_q), 32'(6));
    req = 4'b0100;
    @(negedge clk);
    chk("abn_grant_idle", 32'(grant), 32'(0));
    chk("abn_ena", 32'(cnt_ena), 32'(0));
    chk("abn_done", 32'(done), 32'(0));
    chk("abn_busy", 32'(busy), 32'(0));
    ptr_m = 2;
    serve(pick(req, ptr_m), 4, 1'b0, "abn_next");
    req = '0;

    // Reset in the middle of RUN
    req = 4'b0001;
    len[0 +: CW] = CW'(30);
    t = 0;
    do begin @(negedge clk); t++; end while (cnt_q != CW'(9) && t < 64);
    chk("mrst_q9", 32'(cnt_q), 32'(9));
    rst = 1'b1;
    #1;
    chk("mrst_grant", 32'(grant), 32'(0));
    chk("mrst_ena", 32'(cnt_ena), 32'(0));
    chk("mrst_clr", 32'(cnt_clr), 32'(1));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_q", 32'(cnt_q), 32'(0));
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    ptr_m = 0;

    // Randomized service: random request masks and lengths, with mid-service jitter
    for (int k = 0; k < 24; k++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req = m;
      for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = CW'($urandom_range(0, 12));
      w = pick(m, ptr_m);
      serve(w, len_of(w), 1'b1, "rand");
    end
    req = '0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cont8b_arbiter.md
Name: cont8b_arbiter

Overview:
Time-slot arbiter that shares one external 8-bit up-counter (clk/rst/ena/Qdata type) between NREQ requesters.
- Each requester asks for an interval of `len` counts.
- The arbiter grants one requester at a time and clears the counter.
- It enables counting until Qdata reaches the requested length, then pulses `done` to the owner.
- Sits between the requester logic and the shared counter instance and is the only driver of that counter's clear and enable.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 8, counter/length width; must match the counter's Qdata width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req  in  NREQ  per-requester request level; held high until done or abandoned
len  in  NREQ*CW  requested count per requester; slice i = len[i*CW +: CW]
grant  out  NREQ  one-hot owner of the counter; all zero when idle
done  out  NREQ  one-cycle pulse to the owner when its interval completes
busy  out  1  high whenever state != IDLE
cnt_clr  out  1  registered, glitch-free clear for the shared counter (drives its rst)
cnt_ena  out  1  registered enable for the shared counter (drives its ena)
cnt_q  in  CW  counter value (Qdata) fed back

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant=0, done=0, busy=0, cnt_ena=0.
  - cnt_clr=1, so the counter is held cleared while the arbiter is in reset.
  - RR pointer=0, len_l=0.
- FSM states: IDLE, CLEAR, RUN, DONE. All outputs are registered (Moore).
- IDLE:
  - cnt_clr=0, cnt_ena=0.
  - If any req bit is set, select winner w by round-robin: search starts at the pointer index, ascending, wrapping at NREQ-1 to 0.
  - On selection: latch len_l = len slice w, set grant = one-hot w, go to CLEAR.
- CLEAR (1 cycle):
  - cnt_clr=1, so cnt_q reads 0 by the next edge.
  - Next state is DONE if len_l==0, otherwise RUN.
- RUN:
  - cnt_ena=1, cnt_clr=0.
  - When cnt_q == len_l-1: go to DONE. The counter performs its final increment on the same edge and holds len_l in DONE.
  - Net result: exactly len_l enabled cycles.
- DONE (1 cycle):
  - cnt_ena=0, done[w]=1, grant still = one-hot w.
  - Next: IDLE with grant=0, pointer=(w+1) mod NREQ.
- Total grant window: len_l+2 cycles. Back-to-back service: one IDLE cycle between grants.
- Abandon: if req[w] falls in CLEAR or RUN:
  - next state is IDLE, grant=0, cnt_ena=0, no done pulse.
  - Pointer advances to w+1.
- Length and request stability:
  - len is sampled only at grant time; changes during service are ignored.
  - req changes from other requesters never pre-empt the current owner.
- len_l = 2^CW-1 (255) is legal: the counter reaches 255 and never wraps.
- Reset mid-operation: all outputs go immediately to their reset values and the in-flight service is lost.
- Invariants:
  - grant is never multi-hot.
  - done is only set in DONE.
  - cnt_clr and cnt_ena are never both high.

Optional Feature:
Macro: CONT8B_ARB_FIXED_PRIO_EN
- Defined: fixed priority. The lowest set req index always wins in IDLE. The pointer register is not implemented; its update in DONE and on abandon is skipped.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset: rst=1 with req=4'b1111 -> grant=0, busy=0, cnt_clr=1, cnt_ena=0. Release rst -> grant=4'b0001 (winner 0) within 1 cycle.
- Single request: req[2]=1, len2=5 -> CLEAR 1 cycle, cnt_ena high exactly 5 cycles, cnt_q=5 when done[2] pulses once, grant low the following cycle.
- Fairness: req=4'b1011 held, all len=3 -> grants in order 0,1,3,0,1,3. With CONT8B_ARB_FIXED_PRIO_EN defined -> grant 0 every time.
- Boundaries, len=0 and len=255:
  - len0=0 -> CLEAR then DONE, cnt_ena never high, cnt_q=0 at done[0].
  - len1=255 -> cnt_ena high 255 cycles, cnt_q=255 at done[1], no wrap.
- Abandon: req[1]=1, len1=20, drop req[1] at the 7th RUN cycle -> next cycle state IDLE, grant=0, cnt_ena=0, done stays 0. A pending req[2] is granted next.
- Reset mid-RUN: assert rst during RUN with cnt_q=9 -> grant and cnt_ena drop asynchronously, cnt_clr=1, cnt_q goes to 0.
